// File: rtl/mult_arb_if.sv
// mult_arb_if: client request, response and multiplier signals shared by mult_arb and its environment
interface mult_arb_if #(
  parameter int WIDTH = 32
);
  logic             req0_valid;
  logic             req1_valid;
  logic [15:0]      req0_a;
  logic [15:0]      req0_b;
  logic [15:0]      req1_a;
  logic [15:0]      req1_b;
  logic             req0_ready;
  logic             req1_ready;
  logic [15:0]      mult_a;
  logic [15:0]      mult_b;
  logic [WIDTH-1:0] mult_product;
  logic             rsp0_valid;
  logic             rsp1_valid;
  logic [WIDTH-1:0] rsp0_data;
  logic [WIDTH-1:0] rsp1_data;
  logic             rsp0_ready;
  logic             rsp1_ready;
  logic             busy;
  modport master (
    output req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
    output mult_product, rsp0_ready, rsp1_ready,
    input  req0_ready, req1_ready, mult_a, mult_b,
    input  rsp0_valid, rsp1_valid, rsp0_data, rsp1_data, busy
  );
  modport slave (
    input  req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
    input  mult_product, rsp0_ready, rsp1_ready,
    output req0_ready, req1_ready, mult_a, mult_b,
    output rsp0_valid, rsp1_valid, rsp0_data, rsp1_data, busy
  );
endinterface

// File: rtl/mult_arb.sv
// mult_arb: shares one pipelined multiplier between two requesters with credit-protected response FIFOs; MULT_ARB_FIXED_PRIO_EN selects fixed priority
module mult_arb #(
  parameter int WIDTH = 32,
  parameter int LAT   = 2,
  parameter int DEPTH = 4
) (
  input logic       clk,
  input logic       rst,
  mult_arb_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(DEPTH + 1);
  logic [1:0]       req_valid, rsp_ready, rsp_valid, elig, gnt, pop, wr;
  logic [15:0]      req_a [2];
  logic [15:0]      req_b [2];
  logic [CW-1:0]    cred_q [2];
  logic [CW-1:0]    cred_d [2];
  logic [PW-1:0]    wp_q [2];
  logic [PW-1:0]    wp_d [2];
  logic [PW-1:0]    rp_q [2];
  logic [PW-1:0]    rp_d [2];
  logic [WIDTH-1:0] mem_q [2][DEPTH];
  logic [WIDTH-1:0] mem_d [2][DEPTH];
  logic [WIDTH-1:0] rsp_data [2];
  logic [LAT-1:0]   tv_q, tv_d, tid_q, tid_d;
  logic             rr_q, rr_d;
  assign req_valid = {bus.req1_valid, bus.req0_valid};
  assign rsp_ready = {bus.rsp1_ready, bus.rsp0_ready};
  assign req_a[0]  = bus.req0_a;
  assign req_a[1]  = bus.req1_a;
  assign req_b[0]  = bus.req0_b;
  assign req_b[1]  = bus.req1_b;
  assign bus.req0_ready = gnt[0];
  assign bus.req1_ready = gnt[1];
  assign bus.mult_a = gnt[1] ? req_a[1] : (gnt[0] ? req_a[0] : 16'd0);
  assign bus.mult_b = gnt[1] ? req_b[1] : (gnt[0] ? req_b[0] : 16'd0);
  assign bus.rsp0_valid = rsp_valid[0];
  assign bus.rsp1_valid = rsp_valid[1];
  assign bus.rsp0_data  = rsp_data[0];
  assign bus.rsp1_data  = rsp_data[1];
  // Credit covers queued plus in-flight results, so any busy state shows up as nonzero credit
  assign bus.busy = (cred_q[0] != '0) || (cred_q[1] != '0);
  // FIFO heads; memory is cleared on reset so an empty head reads zero
  always_comb begin
    for (int n = 0; n < 2; n++) begin
      rsp_valid[n] = wp_q[n] != rp_q[n];
      rsp_data[n]  = mem_q[n][rp_q[n][AW-1:0]];
    end
  end
  // Eligibility from registered credit only, then a single grant; rr_q high means requester 1 is preferred
  always_comb begin
    for (int n = 0; n < 2; n++) elig[n] = req_valid[n] && (cred_q[n] < CW'(DEPTH));
`ifdef MULT_ARB_FIXED_PRIO_EN
    gnt[0] = elig[0];
    gnt[1] = elig[1] && !elig[0];
`else
    gnt[0] = elig[0] && (!elig[1] || !rr_q);
    gnt[1] = elig[1] && (!elig[0] || rr_q);
`endif
    rr_d = gnt[0] ? 1'b1 : (gnt[1] ? 1'b0 : rr_q);
  end
  // Tag pipeline carries {valid, id} alongside the multiplier so the product lands in the right FIFO
  always_comb begin
    tv_d     = tv_q;
    tid_d    = tid_q;
    tv_d[0]  = |gnt;
    tid_d[0] = gnt[1];
    for (int i = 1; i < LAT; i++) begin
      tv_d[i]  = tv_q[i-1];
      tid_d[i] = tid_q[i-1];
    end
  end
  // FIFO write from the tag head, pops from the response side, and credit bookkeeping
  always_comb begin
    mem_d = mem_q;
    for (int n = 0; n < 2; n++) begin
      wr[n]     = tv_q[LAT-1] && (tid_q[LAT-1] == 1'(n));
      pop[n]    = rsp_valid[n] && rsp_ready[n];
      if (wr[n]) mem_d[n][wp_q[n][AW-1:0]] = bus.mult_product;
      wp_d[n]   = wp_q[n] + PW'(wr[n]);
      rp_d[n]   = rp_q[n] + PW'(pop[n]);
      cred_d[n] = cred_q[n] + CW'(gnt[n]) - CW'(pop[n]);
    end
  end
  // State registers; reset discards in-flight tags and queued results
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_q  <= 1'b0;
      tv_q  <= '0;
      tid_q <= '0;
      for (int n = 0; n < 2; n++) begin
        cred_q[n] <= '0;
        wp_q[n]   <= '0;
        rp_q[n]   <= '0;
        for (int i = 0; i < DEPTH; i++) mem_q[n][i] <= '0;
      end
    end else begin
      rr_q   <= rr_d;
      tv_q   <= tv_d;
      tid_q  <= tid_d;
      cred_q <= cred_d;
      wp_q   <= wp_d;
      rp_q   <= rp_d;
      mem_q  <= mem_d;
    end
  end
endmodule

// File: tb/tb_mult_arb.sv
// tb_mult_arb: table-driven and sequence checks of mult_arb against a queue scoreboard
module tb_mult_arb;
  localparam int WIDTH = 32;
  localparam int LAT   = 2;
  localparam int DEPTH = 4;
  typedef struct {
    bit          rq;
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] p;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] q0 [$];
  logic [31:0] q1 [$];
  logic [WIDTH-1:0] mp [LAT];
  vec_t vt [8];
  int acc, i0, i1;
  always #5 clk = ~clk;
  mult_arb_if #(.WIDTH(WIDTH)) bus ();
  mult_arb #(.WIDTH(WIDTH), .LAT(LAT), .DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));
  // external multiplier model: product valid LAT-1 edges after operand sample, written by the DUT one edge later
  always @(posedge clk) begin
    mp[0] <= WIDTH'(bus.mult_a) * WIDTH'(bus.mult_b);
    for (int i = 1; i < LAT; i++) mp[i] <= mp[i-1];
  end
  assign bus.mult_product = mp[LAT-1];
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask
  task automatic rst_vals(input string nm);
    chk({nm, "_rdy0"}, bus.req0_ready, 0);
    chk({nm, "_rdy1"}, bus.req1_ready, 0);
    chk({nm, "_v0"}, bus.rsp0_valid, 0);
    chk({nm, "_v1"}, bus.rsp1_valid, 0);
    chk({nm, "_d0"}, bus.rsp0_data, 0);
    chk({nm, "_d1"}, bus.rsp1_data, 0);
    chk({nm, "_busy"}, bus.busy, 0);
    chk({nm, "_ma"}, bus.mult_a, 0);
    chk({nm, "_mb"}, bus.mult_b, 0);
  endtask
  // response scoreboard: every pop must match the oldest expected result of that requester
  always @(negedge clk) begin
    if (rst) begin
      if (bus.rsp0_valid && bus.rsp0_ready) begin
        if (q0.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL rsp0_unexpected: got %0h want none", bus.rsp0_data);
        end else chk("rsp0_data", bus.rsp0_data, q0.pop_front());
      end
      if (bus.rsp1_valid && bus.rsp1_ready) begin
        if (q1.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL rsp1_unexpected: got %0h want none", bus.rsp1_data);
        end else chk("rsp1_data", bus.rsp1_data, q1.pop_front());
      end
    end
  end
  task automatic issue(input bit rq, input logic [15:0] a, input logic [15:0] b, input logic [31:0] p);
    bit ok = 1'b0;
    if (rq) begin bus.req1_a = a; bus.req1_b = b; bus.req1_valid = 1'b1; end
    else begin bus.req0_a = a; bus.req0_b = b; bus.req0_valid = 1'b1; end
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      ok = rq ? bus.req1_ready : bus.req0_ready;
    end
    chk("issue_grant", ok, 1);
    chk("issue_excl", rq ? bus.req0_ready : bus.req1_ready, 0);
    if (ok && rq) q1.push_back(p);
    if (ok && !rq) q0.push_back(p);
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
  endtask
  task automatic drain(input string nm);
    bit done = 1'b0;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.rsp0_ready = 1'b1;
    bus.rsp1_ready = 1'b1;
    for (int k = 0; k < 60 && !done; k++) begin
      @(negedge clk);
      done = !bus.busy && q0.size() == 0 && q1.size() == 0;
    end
    chk({nm, "_drained"}, done, 1);
    chk({nm, "_left0"}, q0.size(), 0);
    chk({nm, "_left1"}, q1.size(), 0);
    @(posedge clk); #1;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end
  initial begin
    vt[0] = '{1'b0, 16'd3, 16'd5, 32'd15};
    vt[1] = '{1'b1, 16'd7, 16'd9, 32'd63};
    vt[2] = '{1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001};
    vt[3] = '{1'b1, 16'hFFFF, 16'hFFFF, 32'hFFFE0001};
    vt[4] = '{1'b1, 16'd0, 16'd1234, 32'd0};
    vt[5] = '{1'b0, 16'd256, 16'd256, 32'h00010000};
    vt[6] = '{1'b1, 16'h8000, 16'd2, 32'h00010000};
    vt[7] = '{1'b0, 16'hFFFF, 16'd1, 32'h0000FFFF};
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    bus.req0_a = '0; bus.req0_b = '0; bus.req1_a = '0; bus.req1_b = '0;
    bus.rsp0_ready = 1'b0; bus.rsp1_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_vals("reset");
    @(posedge clk); #1 rst = 1'b1;
    // single issue latency and busy fall
    bus.rsp0_ready = 1'b1; bus.rsp1_ready = 1'b1;
    bus.req0_a = 16'd3; bus.req0_b = 16'd5; bus.req0_valid = 1'b1;
    @(negedge clk);
    chk("si_ready", bus.req0_ready, 1);
    chk("si_mult_a", bus.mult_a, 3);
    chk("si_mult_b", bus.mult_b, 5);
    q0.push_back(32'd15);
    @(posedge clk); #1 bus.req0_valid = 1'b0;
    @(negedge clk);
    chk("si_v_e0", bus.rsp0_valid, 0);
    chk("si_busy_e0", bus.busy, 1);
    @(negedge clk) chk("si_v_e1", bus.rsp0_valid, 0);
    @(negedge clk);
    chk("si_v_e2", bus.rsp0_valid, 1);
    chk("si_d_e2", bus.rsp0_data, 15);
    @(negedge clk);
    chk("si_v_e3", bus.rsp0_valid, 0);
    chk("si_busy_e3", bus.busy, 0);
    @(posedge clk); #1;
    // table-driven single issues on both requesters
    for (int i = 0; i < 8; i++) issue(vt[i].rq, vt[i].a, vt[i].b, vt[i].p);
    drain("table");
    // reset one cycle after an accept; the product emerges after release and must be dropped
    bus.req1_a = 16'd7; bus.req1_b = 16'd9; bus.req1_valid = 1'b1;
    @(negedge clk) chk("mid_grant", bus.req1_ready, 1);
    @(posedge clk); #1 bus.req1_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    #1 rst_vals("mid_async");
    #1 rst = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("mid_v0", bus.rsp0_valid, 0);
      chk("mid_v1", bus.rsp1_valid, 0);
      chk("mid_busy", bus.busy, 0);
    end
    @(posedge clk); #1;
`ifndef MULT_ARB_FIXED_PRIO_EN
    // contention: grants alternate starting with requester 0 after reset
    i0 = 0; i1 = 0;
    bus.req0_a = 16'd0; bus.req0_b = 16'd2; bus.req1_a = 16'd100; bus.req1_b = 16'd2;
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("rr_g0", bus.req0_ready, (k % 2) == 0);
      chk("rr_g1", bus.req1_ready, (k % 2) == 1);
      if (bus.req0_ready) begin q0.push_back(32'(2 * i0)); i0++; end
      if (bus.req1_ready) begin q1.push_back(32'(2 * (100 + i1))); i1++; end
      @(posedge clk); #1;
      bus.req0_a = 16'(i0);
      bus.req1_a = 16'(100 + i1);
    end
    drain("rr");
`else
    // fixed priority: requester 0 wins until its credit is exhausted
    bus.rsp0_ready = 1'b0; bus.rsp1_ready = 1'b0;
    bus.req0_a = 16'd2; bus.req0_b = 16'd3; bus.req1_a = 16'd4; bus.req1_b = 16'd5;
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("fp_g0", bus.req0_ready, k < 4);
      chk("fp_g1", bus.req1_ready, k >= 4);
      if (bus.req0_ready) q0.push_back(32'd6);
      if (bus.req1_ready) q1.push_back(32'd20);
      @(posedge clk); #1;
    end
    drain("fp");
`endif
    // backpressure: credit limits outstanding results to DEPTH
    acc = 0;
    bus.rsp0_ready = 1'b0; bus.rsp1_ready = 1'b1;
    bus.req0_a = 16'd1; bus.req0_b = 16'd3; bus.req0_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus.req0_ready) begin q0.push_back(32'(bus.req0_a) * 32'd3); acc++; end
      @(posedge clk); #1 bus.req0_a = 16'(acc + 1);
    end
    chk("bp_accepts", acc, DEPTH);
    @(negedge clk) chk("bp_stall", bus.req0_ready, 0);
    @(posedge clk); #1 bus.rsp0_ready = 1'b1;
    @(negedge clk) chk("bp_pop_cycle", bus.req0_ready, 0);
    @(posedge clk); #1 bus.rsp0_ready = 1'b0;
    @(negedge clk);
    chk("bp_refill", bus.req0_ready, 1);
    if (bus.req0_ready) begin q0.push_back(32'(bus.req0_a) * 32'd3); acc++; end
    @(posedge clk); #1 bus.req0_a = 16'(acc + 1);
    @(negedge clk) chk("bp_full_again", bus.req0_ready, 0);
    @(posedge clk); #1;
    drain("bp");
    chk("bp_total", acc, DEPTH + 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
